// File: rtl/sd_110_pkg.sv
// Shared state encodings and event helpers for the sd_110 serial-pattern scheduler.
// Used by sd_110_step and sd_110_scheduler.
package sd_110_pkg;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;
    localparam logic [2:0] S5 = 3'b101;

    // A toggle event is entering the "seen 110" region or leaving it again.
    function automatic logic is_toggle_event(input logic [2:0] cur, input logic [2:0] nxt);
        return ((cur == S2) && (nxt == S3)) || ((cur == S5) && (nxt == S0));
    endfunction

    function automatic logic is_toggle_state(input logic [2:0] st);
        return (st == S3) || (st == S4) || (st == S5);
    endfunction

endpackage

// File: rtl/sd_110_step.sv
// Combinational detector step shared by all channels: next state and toggle event
// for one context and one incoming bit.
module sd_110_step
    import sd_110_pkg::*;
(
    input  logic [2:0] state,
    input  logic       din,
    output logic [2:0] next_state,
    output logic       toggle_evt
);

    always_comb begin
        next_state = S0;
        case (state)
            S0:      next_state = din ? S1 : S0;
            S1:      next_state = din ? S2 : S1;
            S2:      next_state = din ? S2 : S3;
            S3:      next_state = din ? S4 : S3;
            S4:      next_state = din ? S5 : S3;
            S5:      next_state = din ? S5 : S0;
            default: next_state = S0;
        endcase
    end

    assign toggle_evt = is_toggle_event(state, next_state);

endmodule

// File: rtl/sd_110_scheduler.sv
// Round-robin time-multiplexed 110-pattern toggle detector over NUM_CH serial channels.
// Optional per-channel saturating match counters are enabled by defining MATCH_COUNT_EN.
module sd_110_scheduler
    import sd_110_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         in_valid,
    input  logic [NUM_CH-1:0]         in_bit,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH-1:0]         ch_clr,
    output logic [NUM_CH-1:0]         out_toggle,
    output logic                      match_pulse,
    output logic [$clog2(NUM_CH)-1:0] match_ch,
    input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]          cnt_data
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [2:0]      ctx_q [NUM_CH];
    logic [CH_W-1:0] ptr_q;
    logic            match_pulse_q;
    logic [CH_W-1:0] match_ch_q;

    logic [NUM_CH-1:0] req;
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;
    logic [2:0]        cur_state;
    logic [2:0]        nxt_state;
    logic              step_evt;
    logic              evt;

    // A channel being cleared is never granted, so clear always wins.
    always_comb begin
        int idx;
        logic [CH_W-1:0] idx_w;
        idx      = 0;
        idx_w    = '0;
        req      = in_valid & ~ch_clr & {NUM_CH{~rst}};
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        in_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = CH_W'(idx);
            if (!gnt_any && req[idx_w]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w;
            end
        end
        if (gnt_any) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign cur_state = ctx_q[gnt_idx];

    sd_110_step u_step (
        .state      (cur_state),
        .din        (in_bit[gnt_idx]),
        .next_state (nxt_state),
        .toggle_evt (step_evt)
    );

    assign evt = gnt_any & step_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= S0;
            end
            ptr_q         <= '0;
            match_pulse_q <= 1'b0;
            match_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) begin
                    ctx_q[i] <= S0;
                end else if (gnt_any && (gnt_idx == CH_W'(i))) begin
                    ctx_q[i] <= nxt_state;
                end
            end
            if (gnt_any) begin
                ptr_q <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            end
            match_pulse_q <= evt;
            if (evt) begin
                match_ch_q <= gnt_idx;
            end
        end
    end

    always_comb begin
        out_toggle = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_toggle[i] = is_toggle_state(ctx_q[i]);
        end
    end

    assign match_pulse = match_pulse_q;
    assign match_ch    = match_ch_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) begin
                    cnt_q[i] <= '0;
                end else if (evt && (gnt_idx == CH_W'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Guard selects beyond NUM_CH when NUM_CH is not a power of two.
    assign cnt_data = (int'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_data       = '0;
`endif

endmodule

// File: tb/tb_sd_110_scheduler.sv
// Scoreboard bench for sd_110_scheduler: directed per-channel bit streams, expected
// match events queued at issue time and checked by an independent monitor.
module tb_sd_110_scheduler;

`ifdef MATCH_COUNT_EN
    localparam int CNT_W_TB = 2;
`else
    localparam int CNT_W_TB = 8;
`endif

    logic          clk;
    logic          rst;
    logic [3:0]    in_valid;
    logic [3:0]    in_bit;
    logic [3:0]    in_ready;
    logic [3:0]    ch_clr;
    logic [3:0]    out_toggle;
    logic          match_pulse;
    logic [1:0]    match_ch;
    logic [1:0]    cnt_sel;
    logic [CNT_W_TB-1:0] cnt_data;

    sd_110_scheduler #(
        .NUM_CH (4),
        .CNT_W  (CNT_W_TB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .ch_clr      (ch_clr),
        .out_toggle  (out_toggle),
        .match_pulse (match_pulse),
        .match_ch    (match_ch),
        .cnt_sel     (cnt_sel),
        .cnt_data    (cnt_data)
    );

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest queued event, in the expected cycle.
    always @(negedge clk) begin
        if (match_pulse) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got match_ch=%0d, required no pulse (cycle %0d)",
                         match_ch, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((int'(match_ch) != e.ch) || (cyc != e.cyc)) begin
                    failures++;
                    $display("FAIL match_event: got ch=%0d cycle=%0d required ch=%0d cycle=%0d",
                             match_ch, cyc, e.ch, e.cyc);
                end
            end
        end else if ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pulse: got none required ch=%0d at cycle %0d", e.ch, e.cyc);
        end
    end

    // Entered just after a posedge; returns just after the next posedge.
    task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr,
                         input logic [3:0] exp_rdy, input int evt_ch, input string name);
        in_valid = v;
        in_bit   = b;
        ch_clr   = clr;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (evt_ch >= 0) begin
            sb.push_back('{evt_ch, cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 4'b1111;
        in_bit   = 4'b1111;
        ch_clr   = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            check("reset_in_ready", 32'(in_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 4'b0000;
        in_bit   = 4'b0000;
        check("reset_out_toggle", 32'(out_toggle), 32'h0);
        check("reset_match_pulse", 32'(match_pulse), 32'h0);
        check("reset_match_ch", 32'(match_ch), 32'h0);
        check("reset_cnt_data", 32'(cnt_data), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int          s1 [6];
        int          t1 [6];
        logic [3:0]  b;
        logic        rb [4];
        rst      = 1'b1;
        in_valid = '0;
        in_bit   = '0;
        ch_clr   = '0;
        cnt_sel  = 2'd3;
        @(posedge clk);
        #1;

        // ch0 alone sends 1,1,0
        reset_dut();
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "t1_b0");
        check("t1_tog_b0", 32'(out_toggle), 32'h0);
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, "t1_b1");
        check("t1_tog_b1", 32'(out_toggle), 32'h0);
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, "t1_b2");
        check("t1_tog_b2", 32'(out_toggle), 32'h1);

        // all channels valid: round-robin 0,1,2,3; two ones then a zero each
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b1111, 4'b0000, 4'(1 << (k % 4)), -1, "t2_ones");
        end
        check("t2_tog_ones", 32'(out_toggle), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 4'b0000, 4'b0000, 4'(1 << k), k, "t2_zero");
        end
        check("t2_tog_zero", 32'(out_toggle), 32'hf);

        // ch1 sends 1,1,0,1,1,0 interleaved with zeros on ch2
        reset_dut();
        s1 = '{1, 1, 0, 1, 1, 0};
        t1 = '{0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            b    = 4'b0000;
            b[1] = s1[i][0];
            drive(4'b0110, b, 4'b0000, 4'b0010, ((i == 2) || (i == 5)) ? 1 : -1, "t3_ch1");
            check("t3_tog1", 32'(out_toggle[1]), 32'(t1[i]));
            check("t3_tog2", 32'(out_toggle[2]), 32'h0);
            b    = 4'b0000;
            b[1] = (i < 5) ? s1[i + 1][0] : 1'b0;
            drive(4'b0110, b, 4'b0000, 4'b0100, -1, "t3_ch2");
        end

        // clear on ch2 in S3 with a same-cycle valid bit
        reset_dut();
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4_b0");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4_b1");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, 2, "t4_b2");
        check("t4_tog_s3", 32'(out_toggle), 32'h4);
        drive(4'b0100, 4'b0100, 4'b0100, 4'b0000, -1, "t4_clr");
        check("t4_tog_clr", 32'(out_toggle), 32'h0);
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, -1, "t4_after");
        check("t4_tog_after", 32'(out_toggle), 32'h0);

        // all channels to S4 (ch0 on to S5), then reset mid-stream
        reset_dut();
        rb = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                drive(4'b1111, {4{rb[r]}}, 4'b0000, 4'(1 << k), (r == 2) ? k : -1, "t5_fill");
            end
        end
        check("t5_tog_s4", 32'(out_toggle), 32'hf);
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0001, -1, "t5_extra");
        check("t5_tog_extra", 32'(out_toggle), 32'hf);
        reset_dut();
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0001, -1, "t5_restart");
        check("t5_tog_restart", 32'(out_toggle), 32'h0);

        // five 110 sequences on ch3
        reset_dut();
        for (int s = 0; s < 5; s++) begin
            drive(4'b1000, 4'b1000, 4'b0000, 4'b1000, -1, "t6_b0");
            drive(4'b1000, 4'b1000, 4'b0000, 4'b1000, -1, "t6_b1");
            drive(4'b1000, 4'b0000, 4'b0000, 4'b1000, 3, "t6_b2");
            if (s == 0) begin
`ifdef MATCH_COUNT_EN
                check("t6_cnt_first", 32'(cnt_data), 32'h1);
`else
                check("t6_cnt_first", 32'(cnt_data), 32'h0);
`endif
            end
        end
        check("t6_tog", 32'(out_toggle), 32'h8);
`ifdef MATCH_COUNT_EN
        check("t6_cnt_sat", 32'(cnt_data), 32'h3);
        drive(4'b0000, 4'b0000, 4'b1000, 4'b0000, -1, "t6_clr");
        check("t6_cnt_clr", 32'(cnt_data), 32'h0);
`else
        check("t6_cnt_tied", 32'(cnt_data), 32'h0);
`endif

        in_valid = '0;
        ch_clr   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_110_scheduler.md
SD_110_SCHEDULER -- requirements
Module: sd_110_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of serial requester channels (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the per-channel match-counter width.
REQ-003 Port list SHALL be:
 clk  input  1  single clock; all logic on posedge.
 rst  input  1  synchronous, active-high reset.
 in_valid  input  NUM_CH  per-channel bit-valid.
 in_bit  input  NUM_CH  per-channel serial data bit.
 in_ready  output  NUM_CH  one-hot grant; transfer when in_valid[i] & in_ready[i].
 ch_clr  input  NUM_CH  per-channel context clear.
 out_toggle  output  NUM_CH  registered per-channel toggle output.
 match_pulse  output  1  one-cycle pulse on any toggle event.
 match_ch  output  $clog2(NUM_CH)  channel of the current match_pulse.
 cnt_sel  input  $clog2(NUM_CH)  counter read select (MATCH_COUNT_EN only).
 cnt_data  output  CNT_W  selected counter value (MATCH_COUNT_EN only).
REQ-004 Reset SHALL be synchronous and active-high on port rst; the single clock SHALL be port clk.

Function
REQ-005 One shared detector step SHALL be time-multiplexed across channels; each channel SHALL own a 3-bit context register holding states S0..S5.
REQ-006 Step transitions SHALL be: S0: 1->S1, 0->S0; S1: 1->S2, 0->S1; S2: 0->S3, 1->S2; S3: 1->S4, 0->S3; S4: 1->S5, 0->S3; S5: 0->S0, 1->S5.
REQ-007 out_toggle[i] SHALL be 1 when context i is S3, S4 or S5, and 0 otherwise, taken directly from the context register.
REQ-008 Arbitration SHALL be round-robin: among channels with in_valid high and ch_clr low, grant the first at or after the priority pointer; at most one in_ready bit high per cycle.
REQ-009 in_ready SHALL be combinational from in_valid, ch_clr and the pointer; it SHALL be all-zero when no channel requests or when rst is high.
REQ-010 On a transfer on channel g, context g SHALL update at that clock edge and the pointer SHALL become (g+1) mod NUM_CH; with no transfer, the pointer SHALL hold.
REQ-011 A toggle event is transition S2->S3 or S5->S0; match_pulse SHALL be 1 in the cycle after the edge at which the event occurs, with match_ch=g; otherwise match_pulse=0 and match_ch holds its last value.
REQ-012 ch_clr[i] SHALL force context i to S0 at the next edge; clear wins over a same-cycle transfer, which is not granted (in_ready[i] low).
REQ-013 Non-granted channels SHALL keep their context unchanged; a valid bit not granted SHALL be held by the requester (no drop inside the block).

Reset
REQ-014 While rst is high at an edge: all contexts->S0, pointer->0, out_toggle->0, match_pulse->0, match_ch->0, counters->0.
REQ-015 A bit presented in a reset cycle SHALL be discarded; operation SHALL resume on the first edge after rst deasserts.

Configuration
REQ-016 Macro MATCH_COUNT_EN defined: each channel SHALL have a CNT_W-bit counter incremented on each toggle event, saturating at all-ones, cleared by ch_clr[i]; cnt_data = counter[cnt_sel] registered-value, combinational read.
REQ-017 Macro MATCH_COUNT_EN undefined: counters SHALL NOT exist and cnt_data SHALL be tied to 0.

Structure
REQ-018 State encodings S0..S5 (3'b000..3'b101) and the toggle-event definition SHALL live in shared package sd_110_pkg.
REQ-019 The next-state/toggle-event function SHALL be a combinational sub-module sd_110_step (inputs state, bit; outputs next state, event), instantiated once.

Verification
REQ-020 Reset then ch0 only sends 1,1,0: in_ready[0]=1 each cycle; out_toggle[0] 0->1 after third bit; match_pulse=1, match_ch=0 one cycle later.
REQ-021 All four channels valid continuously: grants cycle 0,1,2,3,0...; each channel receives exactly one bit per 4 cycles.
REQ-022 Ch1 sends 1,1,0,1,1,0 interleaved with ch2 traffic: out_toggle[1] goes 1 then 0; out_toggle[2] unaffected.
REQ-023 ch_clr[2] with in_valid[2] in same cycle from S3: in_ready[2]=0, context 2 -> S0, out_toggle[2]=0.
REQ-024 Reset asserted mid-stream with channels in S4: all out_toggle=0, pointer restarts at ch0.
REQ-025 With MATCH_COUNT_EN, CNT_W=2: five 110 sequences on ch3 -> cnt_data (cnt_sel=3) reads 3, saturated.
